// File: rtl/twos_pkg.sv
// Shared types and constants for the two's-complement to sign-magnitude decoder.
// Holds the FSM state encoding, the default width and the bit-counter sizing helper.
package twos_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int TWOS_W = 4;

   // Bits needed to count from 0 up to width inclusive
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/twos_serial_bit.sv
// One serial step of the "copy through first 1, then invert" negation rule.
// Keeps the seen_one history and emits the magnitude bit for the current input bit.
module twos_serial_bit
   import twos_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clear,
   input  logic b,
   input  logic sign,
   output logic obit
);

   logic seen_one;

   // Remember whether a 1 has already passed through in this word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen_one <= 1'b0;
      end else if (clear) begin
         seen_one <= 1'b0;
      end else if (en) begin
         seen_one <= seen_one | b;
      end
   end

   // Positive words pass unchanged; negative words invert after the first 1
   always_comb begin
      obit = b;
      if (sign && seen_one) begin
         obit = ~b;
      end
   end

endmodule

// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude decoder with valid/ready on both sides.
// Optional macro TWOS_TO_SIGNMAG_FASTPOS_EN lets positive words bypass the serial pass.
module twos_to_signmag
   import twos_pkg::*;
#(
   parameter int WIDTH = TWOS_W
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign,
   output logic [WIDTH-1:0] mag
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             shift_en;
   logic             fast_load;
   logic             last_bit;
   logic             obit;

   assign in_ready = (state == IDLE) & ~rst;
   assign last_bit = (cnt == CW'(WIDTH - 1));

   twos_serial_bit u_bit (
      .clk   (clk),
      .rst   (rst),
      .en    (shift_en),
      .clear (accept),
      .b     (sreg[0]),
      .sign  (sign),
      .obit  (obit)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath strobes
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      shift_en  = 1'b0;
      fast_load = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
`ifdef TWOS_TO_SIGNMAG_FASTPOS_EN
            if (!sign) begin
               fast_load = 1'b1;
               state_nxt = DONE;
            end else begin
               shift_en = 1'b1;
               if (last_bit) begin
                  state_nxt = DONE;
               end
            end
`else
            shift_en = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture, serial shift and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg      <= '0;
         cnt       <= '0;
         sign      <= 1'b0;
         mag       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_nxt == DONE);
         if (accept) begin
            sreg <= x;
            cnt  <= '0;
            sign <= x[WIDTH-1];
            mag  <= '0;
         end
         if (shift_en) begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
            mag  <= {obit, mag[WIDTH-1:1]};
         end
         if (fast_load) begin
            mag <= sreg;
         end
      end
   end

endmodule

// File: tb/tb_twos_to_signmag.sv
// Directed bench for twos_to_signmag with a word-level reference model.
// Honours TWOS_TO_SIGNMAG_FASTPOS_EN for the expected positive-input latency.
module tb_twos_to_signmag;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic         out_valid;
   logic         out_ready;
   logic         sign;
   logic [W-1:0] mag;

   int checks = 0;
   int failures = 0;

   logic [W:0] expq[$];

   twos_to_signmag #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sign      (sign),
      .mag       (mag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Sign plus absolute value of the word read as a signed number
   function automatic logic [W:0] model(input logic [W-1:0] v);
      int sv;
      int a;
      sv = int'($signed(v));
      a = (sv < 0) ? -sv : sv;
      return {v[W-1], a[W-1:0]};
   endfunction

   function automatic int lat_of(input logic [W-1:0] v);
`ifdef TWOS_TO_SIGNMAG_FASTPOS_EN
      return v[W-1] ? W : 1;
`else
      return W;
`endif
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
      end else if (out_valid) begin
         if (expq.size() == 0) begin
            chk("spurious_out", {out_valid, sign, mag}, '0);
         end else begin
            chk("model_out", {sign, mag}, expq[0]);
            if (out_ready) void'(expq.pop_front());
         end
      end
   end

   task automatic send(input logic [W-1:0] v, input int hold,
                       output logic s, output logic [W-1:0] m);
      int n;
      s = 1'b0;
      m = '0;
      out_ready = (hold == 0);
      in_valid = 1'b1;
      x = v;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 40);
      chk("in_ready_wait", in_ready, 1'b1);
      @(posedge clk);
      expq.push_back(model(v));
      #1;
      in_valid = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_valid && n < 40);
      chk("latency", n, lat_of(v));
      s = sign;
      m = mag;
      repeat (hold) begin
         in_valid = 1'b1;
         x = 4'b0001;
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_valid", out_valid, 1'b1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_valid", out_valid, 1'b0);
      chk("post_ready", in_ready, 1'b1);
   endtask

   logic [W-1:0] vx[7] = '{4'b0101, 4'b1011, 4'b1111, 4'b1000,
                           4'b0000, 4'b0111, 4'b0110};
   logic [W:0]   vr[7] = '{5'b00101, 5'b10101, 5'b10001, 5'b11000,
                           5'b00000, 5'b00111, 5'b00110};

   initial begin
      logic         s;
      logic [W-1:0] m;
      int           n;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      x = '0;
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_out", {sign, mag}, '0);
      chk("pin_min", model(4'b1000), 5'b11000);
      chk("pin_m5", model(4'b1011), 5'b10101);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("idle_ready", in_ready, 1'b1);

      for (int i = 0; i < 7; i++) begin
         send(vx[i], 0, s, m);
         chk("lit_vec", {s, m}, vr[i]);
      end

      send(4'b1110, 3, s, m);
      chk("lit_bp", {s, m}, 5'b10010);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("bp_no_extra", out_valid, 1'b0);
      end

      in_valid = 1'b1;
      x = 4'b1001;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 40);
      chk("rst_t_ready", in_ready, 1'b1);
      @(posedge clk);
      expq.push_back(model(4'b1001));
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_valid", out_valid, 1'b0);
      chk("abort_out", {sign, mag}, '0);
      chk("abort_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(4'b0011, 0, s, m);
      chk("lit_after_rst", {s, m}, 5'b00011);

      send(4'b1010, 0, s, m);
      chk("lit_m6", {s, m}, 5'b10110);
      send(4'b1001, 0, s, m);
      chk("lit_m7", {s, m}, 5'b10111);

      repeat (2) @(posedge clk);
      chk("queue_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
